i_fetch_ctrl: RTL and testbench

// Instruction-fetch sequencer between the PC/redirect logic and a byte-organised instruction store.
// - Issues one byte read per beat over a req/ack port.
// - Assembles DPW/ElemWidth beats little-endian into one 32-bit instruction.
// - Presents the instruction to decode over a valid/ready handshake.
// - Owns the fetch PC: advances it by 4 on each accepted instruction, reloads it on redirect.
// - Flags misaligned or out-of-range PCs.

---
 rtl/i_fetch_ctrl.sv | 152 +++++++++++++++
 tb/tb_i_fetch_ctrl.sv | 243 ++++++++++++++++++++++++
 2 files changed

// File: rtl/i_fetch_ctrl.sv
// Instruction-fetch sequencer: byte beats from the instruction store are packed into one instruction for decode.
// Latency: first beat request 1 cycle after reset/redirect/accept; instr_valid_o 4 beats later (5-cycle peak rate).
// Backpressure: HOLD keeps instr_o/pc_o frozen and issues no requests until instr_ready_i; redirect pre-empts everything.
//
// Ports:
//   clk, rst                    clock (rising edge), asynchronous active-high reset
//   redirect_i, redirect_pc_i   load a new fetch PC (branch/jump/flush)
//   mem_req_o, mem_addr_o       one-element read request, address = pc + beat index
//   mem_rdata_i, mem_ack_i      read data and beat completion (only looked at while requesting)
//   instr_valid_o, instr_ready_i, instr_o, pc_o   instruction handshake towards decode
//   fault_o                     fetch PC misaligned or outside the store

module i_fetch_ctrl #(
   parameter int DPW       = 32,
   parameter int ElemWidth = 8,
   parameter int MemDepth  = 120,
   parameter int ResetPC   = 0
) (
   input  logic                 clk,
   input  logic                 rst,
   input  logic                 redirect_i,
   input  logic [DPW-1:0]       redirect_pc_i,
   output logic                 mem_req_o,
   output logic [DPW-1:0]       mem_addr_o,
   input  logic [ElemWidth-1:0] mem_rdata_i,
   input  logic                 mem_ack_i,
   output logic                 instr_valid_o,
   input  logic                 instr_ready_i,
   output logic [DPW-1:0]       instr_o,
   output logic [DPW-1:0]       pc_o,
   output logic                 fault_o
);

   localparam int Beats = DPW / ElemWidth;
   localparam int BW    = (Beats > 1) ? $clog2(Beats) : 1;

   // Highest PC whose whole instruction still lies inside the store.
   localparam logic [DPW-1:0] LastPc  = DPW'(MemDepth - Beats);
   localparam logic [DPW-1:0] PcStep  = DPW'(4);
   localparam logic [DPW-1:0] PcReset = DPW'(ResetPC);
   localparam logic [BW-1:0]  LastBeat = BW'(Beats - 1);

   typedef enum logic [1:0] {
      ST_FETCH = 2'd0,
      ST_HOLD  = 2'd1,
      ST_FAULT = 2'd2
   } state_t;

   state_t             state, state_nxt;
   logic [DPW-1:0]     pc, pc_nxt;
   logic [BW-1:0]      beat_cnt, beat_nxt;
   logic [DPW-1:0]     instr_q, instr_nxt;
   logic [DPW-1:0]     pc_q, pc_q_nxt;
   logic [DPW-1:0]     pc_inc;

   // Full-width compare: a huge PC must not alias into range by truncation.
   function automatic logic out_of_range(input logic [DPW-1:0] a);
      return (a[1:0] != 2'b00) || (a > LastPc);
   endfunction

   assign pc_inc     = pc + PcStep;
   assign mem_addr_o = pc + {{(DPW-BW){1'b0}}, beat_cnt};
   assign instr_o    = instr_q;
   assign pc_o       = pc_q;

   // State register
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         state <= ST_FETCH;
      end else begin
         state <= state_nxt;
      end
   end

   // Datapath registers
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         pc       <= PcReset;
         beat_cnt <= '0;
         instr_q  <= '0;
         pc_q     <= PcReset;
      end else begin
         pc       <= pc_nxt;
         beat_cnt <= beat_nxt;
         instr_q  <= instr_nxt;
         pc_q     <= pc_q_nxt;
      end
   end

   // Next state, datapath updates and outputs
   always_comb begin
      state_nxt     = state;
      pc_nxt        = pc;
      beat_nxt      = beat_cnt;
      instr_nxt     = instr_q;
      pc_q_nxt      = pc_q;
      mem_req_o     = 1'b0;
      instr_valid_o = 1'b0;
      fault_o       = 1'b0;

      case (state)
         ST_FETCH: begin
            // Held low while reset is asserted so the first request
            // appears only once reset has been released.
            mem_req_o = !rst;
            if (mem_ack_i) begin
               for (int b = 0; b < Beats; b++) begin
                  if (beat_cnt == BW'(b)) begin
                     instr_nxt[b*ElemWidth +: ElemWidth] = mem_rdata_i;
                  end
               end
               if (beat_cnt == LastBeat) begin
                  beat_nxt  = '0;
                  pc_q_nxt  = pc;
                  state_nxt = ST_HOLD;
               end else begin
                  beat_nxt = beat_cnt + BW'(1);
               end
            end
         end

         ST_HOLD: begin
            instr_valid_o = 1'b1;
            if (instr_ready_i) begin
               pc_nxt    = pc_inc;
               state_nxt = out_of_range(pc_inc) ? ST_FAULT : ST_FETCH;
            end
         end

         ST_FAULT: begin
            fault_o = 1'b1;
         end

         default: begin
            state_nxt = ST_FETCH;
         end
      endcase

      // Redirect overrides everything computed above: any ack or transfer
      // in this cycle is dropped and partially assembled bytes are left
      // unused (the next fetch overwrites every beat).
      if (redirect_i) begin
         pc_nxt        = redirect_pc_i;
         beat_nxt      = '0;
         instr_nxt     = instr_q;
         pc_q_nxt      = pc_q;
         instr_valid_o = 1'b0;
         state_nxt     = out_of_range(redirect_pc_i) ? ST_FAULT : ST_FETCH;
      end
   end

endmodule

// File: tb/tb_i_fetch_ctrl.sv
// Directed bench for i_fetch_ctrl: table of fetch records plus hand-written
// corner sequences (mid-fetch redirect, faults, ready+redirect, async reset).
module tb_i_fetch_ctrl;

   logic        clk = 1'b0;
   logic        rst;
   logic        redirect_i;
   logic [31:0] redirect_pc_i;
   logic        mem_req_o;
   logic [31:0] mem_addr_o;
   logic [7:0]  mem_rdata_i;
   logic        mem_ack_i;
   logic        instr_valid_o;
   logic        instr_ready_i;
   logic [31:0] instr_o;
   logic [31:0] pc_o;
   logic        fault_o;

   int checks = 0;
   int errors = 0;

   logic [7:0] store [0:119];

   typedef struct {
      logic        redir;
      logic [31:0] tgt;
      int          ack_wait;
      int          hold;
      logic [31:0] exp_instr;
      logic [31:0] exp_pc;
   } vec_t;

   vec_t vecs [5];

   i_fetch_ctrl #(
      .DPW(32), .ElemWidth(8), .MemDepth(120), .ResetPC(0)
   ) dut (
      .clk           (clk),
      .rst           (rst),
      .redirect_i    (redirect_i),
      .redirect_pc_i (redirect_pc_i),
      .mem_req_o     (mem_req_o),
      .mem_addr_o    (mem_addr_o),
      .mem_rdata_i   (mem_rdata_i),
      .mem_ack_i     (mem_ack_i),
      .instr_valid_o (instr_valid_o),
      .instr_ready_i (instr_ready_i),
      .instr_o       (instr_o),
      .pc_o          (pc_o),
      .fault_o       (fault_o)
   );

   always #5 clk = ~clk;

   task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
      checks++;
      if (act !== exp) begin
         errors++;
         $display("FAIL %s: got %h, expected %h", name, act, exp);
      end
   endtask

   task automatic step();
      @(posedge clk);
      #1;
   endtask

   task automatic redirect_to(input logic [31:0] tgt);
      redirect_i    = 1'b1;
      redirect_pc_i = tgt;
      step();
      redirect_i = 1'b0;
   endtask

   // Drives the beats of one fetch at pc (ack after wt idle cycles each),
   // checks addresses, then checks the HOLD outputs.
   task automatic fetch_chk(input logic [31:0] pc, input int wt, input logic [31:0] exp_instr);
      for (int b = 0; b < 4; b++) begin
         for (int w = 0; w < wt; w++) begin
            mem_ack_i = 1'b0;
            #1;
            chk("wait_req", {31'd0, mem_req_o}, 32'd1);
            chk("wait_addr", mem_addr_o, pc + b);
            step();
         end
         mem_ack_i   = 1'b1;
         mem_rdata_i = store[pc + b];
         #1;
         chk("beat_req", {31'd0, mem_req_o}, 32'd1);
         chk("beat_addr", mem_addr_o, pc + b);
         step();
      end
      mem_ack_i = 1'b0;
      #1;
      chk("hold_valid", {31'd0, instr_valid_o}, 32'd1);
      chk("hold_instr", instr_o, exp_instr);
      chk("hold_pc", pc_o, pc);
      chk("hold_req", {31'd0, mem_req_o}, 32'd0);
      chk("hold_fault", {31'd0, fault_o}, 32'd0);
   endtask

   task automatic accept();
      instr_ready_i = 1'b1;
      step();
      instr_ready_i = 1'b0;
   endtask

   task automatic chk_faulted(input string name);
      #1;
      chk({name, "_fault"}, {31'd0, fault_o}, 32'd1);
      chk({name, "_req"}, {31'd0, mem_req_o}, 32'd0);
      chk({name, "_valid"}, {31'd0, instr_valid_o}, 32'd0);
   endtask

   initial begin
      for (int i = 0; i < 120; i++) store[i] = 8'(i);
      store[0]  = 8'h03; store[1]  = 8'h22; store[2]  = 8'h02; store[3]  = 8'h00;
      store[4]  = 8'h83; store[5]  = 8'hA2; store[6]  = 8'h42; store[7]  = 8'h00;
      store[8]  = 8'h33; store[9]  = 8'h83; store[10] = 8'h42; store[11] = 8'h00;
      store[12] = 8'h23; store[13] = 8'h24; store[14] = 8'h60; store[15] = 8'h00;

      //          redir  target  wait hold  instr          pc
      vecs[0] = '{1'b0, 32'd0,   0,   3,   32'h00022203, 32'd0};
      vecs[1] = '{1'b0, 32'd0,   0,   0,   32'h0042A283, 32'd4};
      vecs[2] = '{1'b0, 32'd0,   2,   0,   32'h00428333, 32'd8};
      vecs[3] = '{1'b1, 32'd40,  0,   1,   32'h2B2A2928, 32'd40};
      vecs[4] = '{1'b1, 32'd116, 1,   1,   32'h77767574, 32'd116};

      rst = 1'b1;
      redirect_i = 1'b0;
      redirect_pc_i = '0;
      mem_rdata_i = '0;
      mem_ack_i = 1'b0;
      instr_ready_i = 1'b0;
      repeat (3) @(posedge clk);
      #1;
      chk("rst_valid", {31'd0, instr_valid_o}, 32'd0);
      chk("rst_req", {31'd0, mem_req_o}, 32'd0);
      chk("rst_fault", {31'd0, fault_o}, 32'd0);
      chk("rst_instr", instr_o, 32'd0);
      chk("rst_pc", pc_o, 32'd0);
      rst = 1'b0;

      // Table-driven fetches
      for (int i = 0; i < 5; i++) begin
         if (vecs[i].redir) begin
            redirect_i    = 1'b1;
            redirect_pc_i = vecs[i].tgt;
            #1;
            chk("redir_valid", {31'd0, instr_valid_o}, 32'd0);
            step();
            redirect_i = 1'b0;
         end
         fetch_chk(vecs[i].exp_pc, vecs[i].ack_wait, vecs[i].exp_instr);
         for (int h = 0; h < vecs[i].hold; h++) begin
            step();
            chk("stall_instr", instr_o, vecs[i].exp_instr);
            chk("stall_pc", pc_o, vecs[i].exp_pc);
            chk("stall_valid", {31'd0, instr_valid_o}, 32'd1);
            chk("stall_req", {31'd0, mem_req_o}, 32'd0);
         end
         accept();
      end

      // pc 116 + 4 = 120 runs off the end of the store
      chk_faulted("pc_wrap");

      // Redirect to 0 clears the fault and fetch resumes
      redirect_to(32'd0);
      #1;
      chk("clear_fault", {31'd0, fault_o}, 32'd0);
      chk("clear_req", {31'd0, mem_req_o}, 32'd1);
      chk("clear_addr", mem_addr_o, 32'd0);
      fetch_chk(32'd0, 0, 32'h00022203);
      accept();

      // Redirect to 12 after three beats of pc 8; the ack in the redirect cycle is dropped
      redirect_to(32'd8);
      for (int b = 0; b < 3; b++) begin
         mem_ack_i   = 1'b1;
         mem_rdata_i = store[8 + b];
         step();
      end
      mem_ack_i   = 1'b1;
      mem_rdata_i = 8'hFF;
      #1;
      chk("mid_addr", mem_addr_o, 32'd11);
      redirect_to(32'd12);
      mem_ack_i = 1'b0;
      fetch_chk(32'd12, 0, 32'h00602423);
      accept();

      // Misaligned / out-of-range redirect targets
      redirect_to(32'd118);
      chk_faulted("redir118");
      redirect_to(32'd6);
      chk_faulted("redir6");
      redirect_to(32'd120);
      chk_faulted("redir120");
      redirect_to(32'd0);
      #1;
      chk("refetch_fault", {31'd0, fault_o}, 32'd0);
      chk("refetch_req", {31'd0, mem_req_o}, 32'd1);

      // ready and redirect together in HOLD: no transfer, pc_o unchanged
      fetch_chk(32'd0, 0, 32'h00022203);
      step();
      instr_ready_i = 1'b1;
      redirect_i    = 1'b1;
      redirect_pc_i = 32'd16;
      #1;
      chk("rr_valid", {31'd0, instr_valid_o}, 32'd0);
      step();
      instr_ready_i = 1'b0;
      redirect_i    = 1'b0;
      #1;
      chk("rr_addr", mem_addr_o, 32'd16);
      chk("rr_pc", pc_o, 32'd0);
      fetch_chk(32'd16, 0, 32'h13121110);
      accept();

      // Asynchronous reset between edges while in HOLD
      fetch_chk(32'd20, 1, 32'h17161514);
      #3;
      rst = 1'b1;
      #1;
      chk("arst_valid", {31'd0, instr_valid_o}, 32'd0);
      chk("arst_instr", instr_o, 32'd0);
      chk("arst_pc", pc_o, 32'd0);
      chk("arst_fault", {31'd0, fault_o}, 32'd0);
      chk("arst_req", {31'd0, mem_req_o}, 32'd0);
      #1;
      rst = 1'b0;
      step();
      #1;
      chk("post_rst_req", {31'd0, mem_req_o}, 32'd1);
      chk("post_rst_addr", mem_addr_o, 32'd0);

      $display("Result: errors=%0d of %0d checks", errors, checks);
      $finish;
   end

endmodule
